// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline stage registers.
//   EXC_W / VADDR_W : exception record field widths
//   EXC_*           : exception codes carried in excode
//   exc_rec_t       : precise-exception record (ex, excode, badvaddr)
//   merge_exc       : combine an older (upstream) record with this stage's record
package pipe_pkg;

    localparam int unsigned EXC_W   = 5;
    localparam int unsigned VADDR_W = 32;

    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic               ex;
        logic [EXC_W-1:0]   excode;
        logic [VADDR_W-1:0] badvaddr;
    } exc_rec_t;

    // The older exception wins; code/badvaddr follow the current stage otherwise.
    function automatic exc_rec_t merge_exc(input exc_rec_t older, input exc_rec_t cur);
        exc_rec_t r;
        r.ex       = older.ex | cur.ex;
        r.excode   = older.ex ? older.excode   : cur.excode;
        r.badvaddr = older.ex ? older.badvaddr : cur.badvaddr;
        return r;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid-tagged storage entry of a pipeline stage.
//   clk, resetn : clock, synchronous active-low reset
//   clr         : empty the slot (all fields zero) next edge
//   load        : write load_data/load_exc and mark valid
//   valid, data, exc : registered slot contents
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  exc_rec_t          load_exc,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output exc_rec_t          exc
);

    // Clear has priority over load so an empty slot always reads as a zero bubble.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            valid <= 1'b0;
            data  <= '0;
            exc   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            exc   <= load_exc;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, flush and hold; merges upstream and current-stage exceptions at push.
//   clk, resetn             : clock, synchronous active-low reset
//   flush, hold             : kill all entries / freeze the stage
//   up_valid/up_ready/up_*  : upstream handshake, payload and exception record
//   cur_*                   : exception raised by this stage
//   dn_valid/dn_ready/dn_*  : downstream handshake, payload and merged exception
//   occ                     : number of held entries
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SKID   = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               hold,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [DATA_W-1:0]  up_data,
    input  logic               up_ex,
    input  logic [EXC_W-1:0]   up_excode,
    input  logic [VADDR_W-1:0] up_badvaddr,
    input  logic               cur_ex,
    input  logic [EXC_W-1:0]   cur_excode,
    input  logic [VADDR_W-1:0] cur_badvaddr,
    output logic               dn_valid,
    input  logic               dn_ready,
    output logic [DATA_W-1:0]  dn_data,
    output logic               dn_ex,
    output logic [EXC_W-1:0]   dn_excode,
    output logic [VADDR_W-1:0] dn_badvaddr,
    output logic [1:0]         occ
);

    exc_rec_t          up_rec, cur_rec, new_exc;
    exc_rec_t          m_exc, s_exc, m_load_exc;
    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data, m_load_data;
    logic              push, pop;
    logic              m_load, m_clr, m_from_s;

    // Record assembly and merge of the entry being written.
    always_comb begin
        up_rec.ex        = up_ex;
        up_rec.excode    = up_excode;
        up_rec.badvaddr  = up_badvaddr;
        cur_rec.ex       = cur_ex;
        cur_rec.excode   = cur_excode;
        cur_rec.badvaddr = cur_badvaddr;
        new_exc          = merge_exc(up_rec, cur_rec);
    end

    // With a skid slot, ready depends only on state and hold.
    assign up_ready = (SKID != 0) ? (~s_valid & ~hold)
                                  : (~hold & (~m_valid | dn_ready));
    assign push     = up_valid & up_ready;
    assign pop      = m_valid & dn_ready & ~hold;

    // Main slot control; with no skid slot s_valid is tied low and the
    // branch needing m_valid & ~pop & push is unreachable.
    always_comb begin
        m_load   = 1'b0;
        m_clr    = flush;
        m_from_s = 1'b0;
        if (!flush) begin
            if (pop && s_valid) begin
                m_load   = 1'b1;
                m_from_s = 1'b1;
            end else if (pop) begin
                if (push) m_load = 1'b1;
                else      m_clr  = 1'b1;
            end else if (push && !m_valid) begin
                m_load = 1'b1;
            end
        end
    end

    // A move from the skid slot carries its already-merged record.
    assign m_load_data = m_from_s ? s_data : up_data;
    assign m_load_exc  = m_from_s ? s_exc  : new_exc;

    pipe_slot #(.DATA_W(DATA_W)) u_main (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (m_clr),
        .load      (m_load),
        .load_data (m_load_data),
        .load_exc  (m_load_exc),
        .valid     (m_valid),
        .data      (m_data),
        .exc       (m_exc)
    );

    if (SKID != 0) begin : g_skid
        logic s_load, s_clr;

        // up_ready is low whenever S holds an entry, so a pop from S never
        // coincides with a push into S.
        assign s_load = ~flush & push & m_valid & ~pop;
        assign s_clr  = flush | (pop & s_valid);

        pipe_slot #(.DATA_W(DATA_W)) u_skid (
            .clk       (clk),
            .resetn    (resetn),
            .clr       (s_clr),
            .load      (s_load),
            .load_data (up_data),
            .load_exc  (new_exc),
            .valid     (s_valid),
            .data      (s_data),
            .exc       (s_exc)
        );
    end else begin : g_no_skid
        assign s_valid = 1'b0;
        assign s_data  = '0;
        assign s_exc   = '0;
    end

    assign dn_valid    = m_valid;
    assign dn_data     = m_data;
    assign dn_ex       = m_exc.ex;
    assign dn_excode   = m_exc.excode;
    assign dn_badvaddr = m_exc.badvaddr;
    assign occ         = 2'(m_valid) + 2'(s_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share one input set and
// are each compared against a queue-based reference of the stage.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = 128;

    typedef struct packed {
        logic [DW-1:0]      data;
        logic               ex;
        logic [EXC_W-1:0]   excode;
        logic [VADDR_W-1:0] badvaddr;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               resetn, flush, hold, up_valid, dn_ready;
    logic [DW-1:0]      up_data;
    logic               up_ex, cur_ex;
    logic [EXC_W-1:0]   up_excode, cur_excode;
    logic [VADDR_W-1:0] up_badvaddr, cur_badvaddr;

    logic               up_ready1, dn_valid1, dn_ex1;
    logic [DW-1:0]      dn_data1;
    logic [EXC_W-1:0]   dn_excode1;
    logic [VADDR_W-1:0] dn_badvaddr1;
    logic [1:0]         occ1;

    logic               up_ready0, dn_valid0, dn_ex0;
    logic [DW-1:0]      dn_data0;
    logic [EXC_W-1:0]   dn_excode0;
    logic [VADDR_W-1:0] dn_badvaddr0;
    logic [1:0]         occ0;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .flush(flush), .hold(hold),
        .up_valid(up_valid), .up_ready(up_ready1), .up_data(up_data),
        .up_ex(up_ex), .up_excode(up_excode), .up_badvaddr(up_badvaddr),
        .cur_ex(cur_ex), .cur_excode(cur_excode), .cur_badvaddr(cur_badvaddr),
        .dn_valid(dn_valid1), .dn_ready(dn_ready), .dn_data(dn_data1),
        .dn_ex(dn_ex1), .dn_excode(dn_excode1), .dn_badvaddr(dn_badvaddr1),
        .occ(occ1)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .flush(flush), .hold(hold),
        .up_valid(up_valid), .up_ready(up_ready0), .up_data(up_data),
        .up_ex(up_ex), .up_excode(up_excode), .up_badvaddr(up_badvaddr),
        .cur_ex(cur_ex), .cur_excode(cur_excode), .cur_badvaddr(cur_badvaddr),
        .dn_valid(dn_valid0), .dn_ready(dn_ready), .dn_data(dn_data0),
        .dn_ex(dn_ex0), .dn_excode(dn_excode0), .dn_badvaddr(dn_badvaddr0),
        .occ(occ0)
    );

    ent_t q1[$];
    ent_t q0[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: check ready, advance the reference at the edge, check outputs.
    task automatic cycle();
        ent_t nw, e1, e0;
        bit   ur1, ur0, push1, push0, pop1, pop0;
        #1;
        ur1 = !hold && (q1.size() < 2);
        ur0 = !hold && (q0.size() == 0 || dn_ready);
        chk("up_ready_s1", DW'(up_ready1), DW'(ur1));
        chk("up_ready_s0", DW'(up_ready0), DW'(ur0));
        nw.data     = up_data;
        nw.ex       = up_ex || cur_ex;
        nw.excode   = up_ex ? up_excode : cur_excode;
        nw.badvaddr = up_ex ? up_badvaddr : cur_badvaddr;
        push1 = up_valid && ur1;
        push0 = up_valid && ur0;
        pop1  = (q1.size() > 0) && dn_ready && !hold;
        pop0  = (q0.size() > 0) && dn_ready && !hold;
        @(posedge clk);
        if (!resetn || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (pop1)  void'(q1.pop_front());
            if (push1) q1.push_back(nw);
            if (pop0)  void'(q0.pop_front());
            if (push0) q0.push_back(nw);
        end
        @(negedge clk);
        e1 = (q1.size() > 0) ? q1[0] : '0;
        e0 = (q0.size() > 0) ? q0[0] : '0;
        chk("dn_valid_s1",    DW'(dn_valid1),    DW'(q1.size() > 0));
        chk("dn_data_s1",     dn_data1,          e1.data);
        chk("dn_ex_s1",       DW'(dn_ex1),       DW'(e1.ex));
        chk("dn_excode_s1",   DW'(dn_excode1),   DW'(e1.excode));
        chk("dn_badvaddr_s1", DW'(dn_badvaddr1), DW'(e1.badvaddr));
        chk("occ_s1",         DW'(occ1),         DW'(q1.size()));
        chk("dn_valid_s0",    DW'(dn_valid0),    DW'(q0.size() > 0));
        chk("dn_data_s0",     dn_data0,          e0.data);
        chk("dn_ex_s0",       DW'(dn_ex0),       DW'(e0.ex));
        chk("dn_excode_s0",   DW'(dn_excode0),   DW'(e0.excode));
        chk("dn_badvaddr_s0", DW'(dn_badvaddr0), DW'(e0.badvaddr));
        chk("occ_s0",         DW'(occ0),         DW'(q0.size()));
    endtask

    task automatic no_exc();
        up_ex = 1'b0; up_excode = '0; up_badvaddr = '0;
        cur_ex = 1'b0; cur_excode = '0; cur_badvaddr = '0;
    endtask

    function automatic logic [EXC_W-1:0] rand_code();
        logic [EXC_W-1:0] codes [7];
        codes = '{EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
        return codes[$urandom_range(0, 6)];
    endfunction

    initial begin
        int peak;
        resetn = 1'b0; flush = 1'b0; hold = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
        up_data = '0;
        no_exc();

        // Unchecked first edge brings both instances out of X.
        @(posedge clk);
        @(negedge clk);
        cycle();
        cycle();
        resetn = 1'b1;

        // Back-to-back stream with downstream always ready.
        dn_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            up_valid = 1'b1;
            up_data  = DW'(k);
            cycle();
            chk("stream_data_s1", dn_data1, DW'(k));
        end
        up_valid = 1'b0;
        cycle();

        // Downstream stall for three cycles mid-stream.
        peak = 0;
        for (int i = 0; i < 12; i++) begin
            up_valid = 1'b1;
            up_data  = DW'(16 + i);
            dn_ready = !(i >= 3 && i <= 5);
            cycle();
            if (int'(occ1) > peak) peak = int'(occ1);
        end
        up_valid = 1'b0;
        dn_ready = 1'b1;
        repeat (3) cycle();
        chk("stall_occ_peak_s1", DW'(peak), DW'(2));

        // Exception merge: upstream wins, then current stage only.
        up_valid = 1'b1;
        up_data  = DW'(32'hE1);
        up_ex = 1'b1; up_excode = EXC_ADEL; up_badvaddr = 32'h1003;
        cur_ex = 1'b1; cur_excode = EXC_OV; cur_badvaddr = 32'h2222;
        cycle();
        chk("merge_excode_s1", DW'(dn_excode1), DW'(4));
        chk("merge_badvaddr_s1", DW'(dn_badvaddr1), DW'(32'h1003));
        no_exc();
        cur_ex = 1'b1; cur_excode = EXC_OV; cur_badvaddr = 32'h0;
        up_data = DW'(32'hE2);
        cycle();
        chk("cur_only_excode_s1", DW'(dn_excode1), DW'(12));
        no_exc();
        up_valid = 1'b0;
        cycle();

        // Fill to two entries, then flush with a coincident push.
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = DW'(32'hA0);
        cycle();
        up_data  = DW'(32'hA1);
        cycle();
        flush    = 1'b1;
        up_data  = DW'(32'hA2);
        cycle();
        chk("flush_occ_s1", DW'(occ1), DW'(0));
        flush    = 1'b0;
        up_valid = 1'b0;
        cycle();

        // Flush at occ=1 with an accepted push: the push is dropped too.
        dn_ready = 1'b1;
        up_valid = 1'b1;
        up_data  = DW'(32'hB0);
        cycle();
        flush    = 1'b1;
        up_data  = DW'(32'hB1);
        cycle();
        flush    = 1'b0;
        up_valid = 1'b0;
        cycle();

        // Hold with one entry and downstream ready: nothing moves.
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = DW'(32'h55);
        cycle();
        hold     = 1'b1;
        dn_ready = 1'b1;
        up_data  = DW'(32'h66);
        repeat (4) begin
            cycle();
            chk("hold_data_s1", dn_data1, DW'(32'h55));
        end
        hold     = 1'b0;
        up_valid = 1'b0;
        cycle();
        chk("hold_release_valid_s1", DW'(dn_valid1), DW'(0));

        // Reset for one cycle in the middle of a stalling stream.
        for (int i = 0; i < 8; i++) begin
            up_valid = 1'b1;
            up_data  = DW'(32'hC0 + i);
            dn_ready = (i % 3) != 1;
            resetn   = (i != 4);
            cycle();
        end
        resetn   = 1'b1;
        up_valid = 1'b0;
        dn_ready = 1'b1;
        repeat (3) cycle();

        // Randomized traffic including rare hold, flush and reset.
        for (int i = 0; i < 300; i++) begin
            up_valid     = ($urandom_range(0, 3) != 0);
            dn_ready     = ($urandom_range(0, 2) != 0);
            hold         = ($urandom_range(0, 11) == 0);
            flush        = ($urandom_range(0, 29) == 0);
            resetn       = ($urandom_range(0, 59) != 0);
            up_data      = {$urandom(), $urandom(), $urandom(), $urandom()};
            up_ex        = ($urandom_range(0, 4) == 0);
            up_excode    = rand_code();
            up_badvaddr  = $urandom();
            cur_ex       = ($urandom_range(0, 4) == 0);
            cur_excode   = rand_code();
            cur_badvaddr = $urandom();
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, flush, and a hold input. It carries a generic payload plus a precise-exception record (ex flag, excode, badvaddr) between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). At capture it merges the exception raised in the current stage with the one arriving from upstream.

## Interface
- `DATA_W`, 128: payload width in bits (pc, alu result, rf/ram control, etc. packed by the instantiating stage).
- `SKID`, 1: 1 = two-entry skid buffer with state-only `up_ready`; 0 = single register with combinational ready pass-through.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `flush` in 1: kill all held entries (exception / eret).
- `hold` in 1: freeze the stage; no push, no pop.
- `up_valid` in 1: upstream entry valid.
- `up_ready` out 1: stage can accept.
- `up_data` in DATA_W: upstream payload.
- `up_ex` in 1: exception already raised by an earlier stage.
- `up_excode` in 5: code for `up_ex`.
- `up_badvaddr` in 32: badvaddr for `up_ex`.
- `cur_ex` in 1: exception raised by this stage; sampled with the accepted transfer.
- `cur_excode` in 5: code for `cur_ex`.
- `cur_badvaddr` in 32: badvaddr for `cur_ex`.
- `dn_valid` out 1: output entry valid.
- `dn_ready` in 1: downstream accepts.
- `dn_data` out DATA_W: output payload.
- `dn_ex` out 1: merged exception flag.
- `dn_excode` out 5: merged exception code.
- `dn_badvaddr` out 32: merged badvaddr.
- `occ` out 2: entries held (0..2; max 1 when SKID=0).

## Operation
- Storage: main slot M drives `dn_*`. Skid slot S exists only when SKID=1.
- Push: `up_valid & up_ready`. Pop: `dn_valid & dn_ready & ~hold`.
- `dn_valid` = M.valid.
- `up_ready`:
  - SKID=1: `~S.valid & ~hold`. It depends only on registered state and `hold`, never on `dn_ready`.
  - SKID=0: `~hold & (~M.valid | dn_ready)`.
- Exception merge at push, applied to the entry written:
  - ex = `up_ex | cur_ex`.
  - excode = `up_ex ? up_excode : cur_excode`.
  - badvaddr = `up_ex ? up_badvaddr : cur_badvaddr`.
  - The older (upstream) exception wins. A move from S to M does not re-merge.
- SKID=1 update rules, per edge when not reset/flush:
  - Pop with S valid: M <= S. If also pushing, S <= new entry, otherwise S empties.
  - Pop with S empty: M <= new entry if pushing, otherwise M empties.
  - No pop and M empty: M <= new entry on push.
  - No pop and M valid: S <= new entry on push.
- SKID=0: M <= new entry on push. Otherwise M empties on pop.
- Priority: reset > flush > hold > normal.
  - Reset or flush: all slots invalid and every field zero next edge. A push coincident with flush is discarded.
  - Flush overrides hold.
- A slot that becomes invalid has all fields cleared to zero, so `dn_*` reads all-zero (bubble) whenever `dn_valid` = 0.
- `hold=1`: the contents of M and S are unchanged, and `dn_valid` stays as is.

## Timing
- Latency 1 cycle: an entry pushed at edge N is on `dn_*` after edge N.
- Throughput 1 entry/cycle with `dn_ready` held high, for both SKID values.
- SKID=1, downstream stalls (`dn_ready` 0) while upstream streams: one extra entry is absorbed into S, and `up_ready` falls one cycle after `dn_ready` falls.
- SKID=1, refill: after `dn_ready` rises, `up_ready` rises the cycle after the first pop.
- Reset values: `dn_valid` 0, `dn_data` 0, `dn_ex` 0, `dn_excode` 0, `dn_badvaddr` 0, `occ` 0. `up_ready` = `~hold` after reset.
- Boundaries:
  - occ=2: `up_ready` 0, no overwrite possible.
  - occ=0 with `dn_ready` 1: no pop.
  - Simultaneous push and pop at occ=1 keeps occ=1.
  - Reset mid-stall empties both slots.

## Structure
- Package `pipe_pkg` holds:
  - `EXC_W=5` and `VADDR_W=32`.
  - Excode constants: `EXC_INT=0`, `EXC_ADEL=4`, `EXC_ADES=5`, `EXC_SYS=8`, `EXC_BP=9`, `EXC_RI=10`, `EXC_OV=12`.
  - A packed struct `exc_rec_t` (ex, excode, badvaddr).
- Sub-module `pipe_slot`: one valid-tagged storage entry with a load port and clear (zeroing) behaviour. It is instantiated as M always and as S when SKID=1 (generate).

## Test plan
- Stream of 8 pushes (data 1..8), `dn_ready`=1, SKID=1 -> `dn_data` 1..8 on consecutive cycles, each 1 cycle after push, occ ≤1.
- SKID=1: `dn_ready` drops for 3 cycles during a stream -> occ reaches 2, `up_ready`=0, no data lost or duplicated, order preserved on resume.
- Push with `up_ex`=1 (excode 4, badvaddr 0x1003) and `cur_ex`=1 (excode 12) -> `dn_ex`=1, `dn_excode`=4, `dn_badvaddr`=0x1003. Push with only `cur_ex` (12, 0x0) -> `dn_excode`=12.
- occ=2 with `flush`=1 and a coincident push -> next cycle occ=0, `dn_valid`=0, all `dn_*`=0, pushed entry absent.
- `hold`=1 for 4 cycles with occ=1 and `dn_ready`=1 -> `dn_data` stable, `up_ready`=0, no pop. Release -> pop occurs.
- SKID=0 instance, `resetn`=0 for 1 cycle mid-stream -> all outputs 0. Same-cycle push/pop at occ=1 keeps occ=1.
